// File: rtl/alu_sched.sv
// Round-robin sequencer for the shared ALU: two valid/ready requesters, a registered operand
// launch, one-cycle result capture, per-owner response with an optional un-accepted-response watchdog.
module alu_sched #(
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_data,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_res,
  output logic [W-1:0] disp_val,
  output logic         disp_src,
  output logic [7:0]   ops_done,
  output logic         err_timeout
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  // Watchdog fires on the TIMEOUT-th RESP cycle (counter starts at 0 on entry).
  localparam bit         WD_EN   = (TIMEOUT != 0);
  localparam logic [7:0] WD_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic           prio_q, owner_q, src_q, err_q;
  logic [W-1:0]   a_q, b_q, res_q, disp_q;
  logic [2:0]     op_q;
  logic [7:0]     ops_q, wd_q;

  logic           grant1, hs, rsp_rdy, wd_expire;

  assign grant1    = req1_valid && (!req0_valid || prio_q);
  assign hs        = (state_q == IDLE) && (req0_valid || req1_valid);
  assign rsp_rdy   = owner_q ? rsp1_ready : rsp0_ready;
  assign wd_expire = WD_EN && (wd_q == WD_LAST) && !rsp_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_rdy || wd_expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = req0_valid && !grant1;
        req1_ready = grant1;
      end
      RESP: begin
        rsp0_valid = !owner_q;
        rsp1_valid = owner_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      owner_q <= 1'b0;
      res_q   <= '0;
      wd_q    <= '0;
      ops_q   <= '0;
      disp_q  <= '0;
      src_q   <= 1'b0;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (hs) begin
        a_q     <= grant1 ? req1_a  : req0_a;
        b_q     <= grant1 ? req1_b  : req0_b;
        op_q    <= grant1 ? req1_op : req0_op;
        owner_q <= grant1;
      end
      if (state_q == EXEC) begin
        res_q <= alu_res;
        wd_q  <= '0;
      end
      // A ready on the deadline cycle takes priority over the drop.
      if (state_q == RESP) begin
        if (rsp_rdy) begin
          ops_q  <= ops_q + 8'd1;
          disp_q <= res_q;
          src_q  <= owner_q;
          prio_q <= ~owner_q;
        end else if (wd_expire) begin
          err_q  <= 1'b1;
          prio_q <= ~owner_q;
        end else begin
          wd_q <= wd_q + 8'd1;
        end
      end
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign rsp_data    = res_q;
  assign disp_val    = disp_q;
  assign disp_src    = src_q;
  assign ops_done    = ops_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: a behavioural ALU, a transaction-level reference model checked every
// cycle, a table of single operations, directed multi-cycle corner cases and a random phase.
module tb_alu_sched;
  localparam int W  = 4;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [W-1:0] rsp_data, alu_a, alu_b, alu_res, disp_val;
  logic [2:0]   alu_op;
  logic         disp_src, err_timeout;
  logic [7:0]   ops_done;

  alu_sched #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .disp_val(disp_val), .disp_src(disp_src), .ops_done(ops_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return {{(W-1){1'b0}}, a < b};
      default: return {{(W-1){1'b0}}, a == b};
    endcase
  endfunction

  assign alu_res = alu_f(alu_a, alu_b, alu_op);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state (transaction level)
  int           m_prio = 0, m_owner = 0, m_since = 0, m_ops = 0, m_src = 0;
  bit           m_busy = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_res = '0, m_disp = '0, m_alu_a = '0, m_alu_b = '0;
  logic [2:0]   m_alu_op = '0;
  int           grants[$];
  int           last_grant = -1;

  task automatic model_reset();
    m_prio = 0; m_owner = 0; m_since = 0; m_ops = 0; m_src = 0;
    m_busy = 1'b0; m_err = 1'b0;
    m_res = '0; m_disp = '0; m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
  endtask

  // Inputs are set at a negedge; this checks one cycle and advances to the next negedge.
  task automatic step();
    int  eg;
    bit  rdy;
    #1;
    last_grant = -1;
    chk("ops_done", int'(ops_done), m_ops % 256);
    chk("disp_val", int'(disp_val), int'(m_disp));
    chk("disp_src", int'(disp_src), m_src);
    chk("err_timeout", int'(err_timeout), int'(m_err));
    chk("alu_a", int'(alu_a), int'(m_alu_a));
    chk("alu_b", int'(alu_b), int'(m_alu_b));
    chk("alu_op", int'(alu_op), int'(m_alu_op));
    if (!m_busy) begin
      eg = -1;
      if (req0_valid && req1_valid) eg = m_prio;
      else if (req0_valid)          eg = 0;
      else if (req1_valid)          eg = 1;
      chk("req0_ready", int'(req0_ready), int'(eg == 0));
      chk("req1_ready", int'(req1_ready), int'(eg == 1));
      chk("rsp0_valid_idle", int'(rsp0_valid), 0);
      chk("rsp1_valid_idle", int'(rsp1_valid), 0);
      if (eg == 0) begin
        m_alu_a = req0_a; m_alu_b = req0_b; m_alu_op = req0_op;
      end else if (eg == 1) begin
        m_alu_a = req1_a; m_alu_b = req1_b; m_alu_op = req1_op;
      end
      if (eg >= 0) begin
        m_busy = 1'b1; m_owner = eg; m_since = 0;
        m_res = alu_f(m_alu_a, m_alu_b, m_alu_op);
        grants.push_back(eg);
        last_grant = eg;
      end
    end else begin
      m_since++;
      chk("req0_ready_busy", int'(req0_ready), 0);
      chk("req1_ready_busy", int'(req1_ready), 0);
      if (m_since == 1) begin
        chk("rsp0_valid_exec", int'(rsp0_valid), 0);
        chk("rsp1_valid_exec", int'(rsp1_valid), 0);
      end else begin
        chk("rsp0_valid", int'(rsp0_valid), int'(m_owner == 0));
        chk("rsp1_valid", int'(rsp1_valid), int'(m_owner == 1));
        chk("rsp_data", int'(rsp_data), int'(m_res));
        rdy = (m_owner == 0) ? rsp0_ready : rsp1_ready;
        if (rdy) begin
          m_ops++; m_disp = m_res; m_src = m_owner; m_prio = 1 - m_owner; m_busy = 1'b0;
        end else if (m_since - 1 == TO) begin
          m_err = 1'b1; m_prio = 1 - m_owner; m_busy = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input int a, input int b, input int op);
    if (p == 0) begin
      req0_valid = 1'b1; req0_a = W'(a); req0_b = W'(b); req0_op = 3'(op);
    end else begin
      req1_valid = 1'b1; req1_a = W'(a); req1_b = W'(b); req1_op = 3'(op);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req0_ready"}, int'(req0_ready), 0);
    chk({tag, "_req1_ready"}, int'(req1_ready), 0);
    chk({tag, "_rsp0_valid"}, int'(rsp0_valid), 0);
    chk({tag, "_rsp1_valid"}, int'(rsp1_valid), 0);
    chk({tag, "_rsp_data"}, int'(rsp_data), 0);
    chk({tag, "_alu_a"}, int'(alu_a), 0);
    chk({tag, "_alu_b"}, int'(alu_b), 0);
    chk({tag, "_alu_op"}, int'(alu_op), 0);
    chk({tag, "_disp_val"}, int'(disp_val), 0);
    chk({tag, "_disp_src"}, int'(disp_src), 0);
    chk({tag, "_ops_done"}, int'(ops_done), 0);
    chk({tag, "_err_timeout"}, int'(err_timeout), 0);
  endtask

  typedef struct {
    int port;
    int a;
    int b;
    int op;
    int exp;
  } vec_t;

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t tbl[9];
    int   cnt;
    bit   h0, h1;
    tbl[0] = '{0, 3, 4, 0, 7};
    tbl[1] = '{0, 5, 7, 1, 14};
    tbl[2] = '{1, 12, 10, 2, 8};
    tbl[3] = '{0, 12, 3, 3, 15};
    tbl[4] = '{1, 6, 5, 4, 3};
    tbl[5] = '{0, 2, 9, 6, 1};
    tbl[6] = '{0, 10, 0, 5, 5};
    tbl[7] = '{0, 7, 7, 7, 1};
    tbl[8] = '{1, 9, 9, 0, 2};

    // Reset
    #2;
    check_reset_vals("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();

    // Table of single operations, response accepted on the first RESP cycle
    for (int i = 0; i < 9; i++) begin
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      set_req(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].op);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      #1;
      chk("tbl_rsp_data", int'(rsp_data), tbl[i].exp);
      chk("tbl_rsp0_valid", int'(rsp0_valid), int'(tbl[i].port == 0));
      chk("tbl_rsp1_valid", int'(rsp1_valid), int'(tbl[i].port == 1));
      step();
      chk("tbl_disp_val", int'(disp_val), tbl[i].exp);
      chk("tbl_disp_src", int'(disp_src), tbl[i].port);
      chk("tbl_ops_done", int'(ops_done), i + 1);
    end

    // Contention: both requesters valid throughout, grants must alternate 0,1,0,1
    grants.delete();
    set_req(0, 8, 3, 1);
    set_req(1, 4, 6, 4);
    for (int i = 0; i < 12; i++) step();
    chk("cont_ops_done", int'(ops_done), 13);
    chk("cont_grants", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("cont_grant_order", grants[i], i % 2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Ready arriving exactly on the deadline cycle completes normally
    rsp0_ready = 1'b0;
    set_req(0, 1, 2, 0);
    step();
    req0_valid = 1'b0;
    step();
    for (int i = 0; i < TO - 1; i++) step();
    rsp0_ready = 1'b1;
    #1;
    chk("dl_rsp0_valid", int'(rsp0_valid), 1);
    step();
    chk("dl_ops_done", int'(ops_done), 14);
    chk("dl_err_timeout", int'(err_timeout), 0);
    chk("dl_disp_val", int'(disp_val), 3);

    // Backpressure until timeout; req1 then wins the next grant
    grants.delete();
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    set_req(0, 4, 1, 1);
    step();
    set_req(0, 6, 6, 0);
    set_req(1, 7, 2, 1);
    cnt = 0;
    for (int i = 0; i < 18; i++) begin
      #1;
      if (rsp0_valid) cnt++;
      step();
    end
    chk("to_valid_cycles", cnt, TO);
    chk("to_err_timeout", int'(err_timeout), 1);
    chk("to_ops_done", int'(ops_done), 14);
    chk("to_grants", grants.size(), 2);
    if (grants.size() >= 2) chk("to_next_grant", grants[1], 1);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("to_drain_ops", int'(ops_done), 15);

    // Asynchronous reset while a response is pending
    rsp1_ready = 1'b0;
    set_req(1, 5, 6, 0);
    step();
    req1_valid = 1'b0;
    step();
    #1;
    chk("rm_rsp1_valid", int'(rsp1_valid), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(0, 2, 2, 0);
    step();
    req0_valid = 1'b0;
    step();
    step();
    chk("rm_after_disp", int'(disp_val), 4);
    chk("rm_after_ops", int'(ops_done), 1);

    // Random traffic; requesters hold a request until it is granted
    h0 = 1'b0; h1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!h0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_a = W'($urandom); req0_b = W'($urandom); req0_op = 3'($urandom);
        h0 = req0_valid;
      end
      if (!h1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 3'($urandom);
        h1 = req1_valid;
      end
      rsp0_ready = ($urandom_range(0, 7) == 0);
      rsp1_ready = ($urandom_range(0, 7) == 0);
      step();
      if (last_grant == 0) h0 = 1'b0;
      if (last_grant == 1) h1 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
